imm_encoder: RTL and testbench

//   Inverse of the immediate generator: packs a 32-bit immediate into the RV32I

---
 rtl/imm_encoder.sv | 136 +++++++++++++
 tb/tb_imm_encoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into the RV32I immediate fields of a
// base instruction word for the selected format, flags immediates that the
// format cannot represent, and counts flagged results as they are consumed.
// Two-stage valid/ready pipeline with full throughput.
//
// imm_sel encoding: 1=I, 2=S, 3=B, 4=J, 5=U; every other value is illegal.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SEL_I = 3'd1;
  localparam logic [2:0] SEL_S = 3'd2;
  localparam logic [2:0] SEL_B = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;
  localparam logic [2:0] SEL_U = 3'd5;

  // stage 1 state
  logic        s1_v;
  logic [2:0]  s1_sel;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_err;

  // stage 2 state drives the outputs directly
  logic        s2_v;

  logic        s1_adv;
  logic        s2_adv;
  logic        rng_err;
  logic [31:0] packed_inst;

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;

  // Representability check on the incoming request: the immediate must equal
  // the sign extension of the field width the format can carry, branch/jump
  // offsets must be even, and U immediates must have a clear low 12 bits.
  always_comb begin
    rng_err = 1'b1;
    case (imm_sel)
      SEL_I, SEL_S: rng_err = (imm[31:11] != {21{imm[11]}});
      SEL_B:        rng_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      SEL_J:        rng_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      SEL_U:        rng_err = (imm[11:0] != 12'd0);
      default:      rng_err = 1'b1;
    endcase
  end

  // Scatter the stage-1 immediate into the format's bit positions; fields not
  // owned by the immediate, and the whole word on error, come from base.
  always_comb begin
    packed_inst = s1_base;
    if (!s1_err) begin
      case (s1_sel)
        SEL_I: packed_inst[31:20] = s1_imm[11:0];
        SEL_S: begin
          packed_inst[31:25] = s1_imm[11:5];
          packed_inst[11:7]  = s1_imm[4:0];
        end
        SEL_B: begin
          packed_inst[31]    = s1_imm[12];
          packed_inst[30:25] = s1_imm[10:5];
          packed_inst[11:8]  = s1_imm[4:1];
          packed_inst[7]     = s1_imm[11];
        end
        SEL_J: begin
          packed_inst[31]    = s1_imm[20];
          packed_inst[30:21] = s1_imm[10:1];
          packed_inst[20]    = s1_imm[11];
          packed_inst[19:12] = s1_imm[19:12];
        end
        SEL_U: packed_inst[31:12] = s1_imm[31:12];
        default: packed_inst = s1_base;
      endcase
    end
  end

  // Stage 1: capture the request and its range-check result when it can move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sel  <= 3'd0;
      s1_imm  <= 32'd0;
      s1_base <= 32'd0;
      s1_err  <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sel  <= imm_sel;
        s1_imm  <= imm;
        s1_base <= base;
        s1_err  <= rng_err;
      end
    end
  end

  // Stage 2: register the packed word; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      out_inst <= 32'd0;
      out_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_inst <= packed_inst;
        out_err  <= s1_err;
      end
    end
  end

  // Count consumed error results, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a
// reference built from the ISA immediate decode and numeric range rules.
module tb_imm_encoder;

  localparam logic [2:0] SEL_I = 3'd1;
  localparam logic [2:0] SEL_S = 3'd2;
  localparam logic [2:0] SEL_B = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;
  localparam logic [2:0] SEL_U = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm, base;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [15:0] err_cnt;
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_inst;
  logic [2:0]  s_err_cnt;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  // narrow counter instance, same stimulus, for saturation
  imm_encoder #(.CNT_W(3)) sat_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .imm_sel(imm_sel), .imm(imm), .base(base), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_inst(s_out_inst), .out_err(s_out_err),
    .err_cnt(s_err_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    bit          has_exact;
    logic [31:0] exact;
  } item_t;

  item_t       q[$];
  int          cnt16, cnt3;
  bit          pend_has, acc, held;
  logic [31:0] pend_exact, held_inst;
  logic        held_err;

  // numeric representability per format
  function automatic bit ref_err(input logic [2:0] sel, input logic [31:0] v);
    int s;
    s = int'($signed(v));
    case (sel)
      SEL_I, SEL_S: return !(s >= -2048 && s <= 2047);
      SEL_B:        return !(s >= -4096 && s <= 4094 && (s % 2) == 0);
      SEL_J:        return !(s >= -1048576 && s <= 1048574 && (s % 2) == 0);
      SEL_U:        return (v % 4096) != 0;
      default:      return 1'b1;
    endcase
  endfunction

  // ISA immediate generator
  function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      SEL_I:   return {{20{i[31]}}, i[31:20]};
      SEL_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      SEL_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      SEL_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      SEL_U:   return {i[31:12], 12'd0};
      default: return 32'd0;
    endcase
  endfunction

  // instruction bits owned by the immediate
  function automatic logic [31:0] imm_mask(input logic [2:0] sel);
    case (sel)
      SEL_I:        return 32'hFFF0_0000;
      SEL_S, SEL_B: return 32'hFE00_0F80;
      SEL_J, SEL_U: return 32'hFFFF_F000;
      default:      return 32'h0;
    endcase
  endfunction

  // One cycle: observe just after the negedge drive, then step to next negedge.
  task automatic tick();
    item_t       it;
    bit          e;
    logic [31:0] m;
    #1;
    acc = 1'b0;
    if (rst_n) begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_inst", out_inst, held_inst);
        chk("hold_err", out_err, held_err);
      end
      held      = out_valid && !out_ready;
      held_inst = out_inst;
      held_err  = out_err;
      chk("err_cnt", err_cnt, cnt16);
      chk("sat_err_cnt", s_err_cnt, cnt3);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          it = q.pop_front();
          e  = ref_err(it.sel, it.imm);
          m  = imm_mask(it.sel);
          chk("out_err", out_err, e);
          if (e) chk("err_inst", out_inst, it.base);
          else begin
            chk("roundtrip", immgen(out_inst, it.sel), it.imm);
            chk("base_bits", out_inst & ~m, it.base & ~m);
          end
          if (it.has_exact) chk("exact_inst", out_inst, it.exact);
          if (e) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt3 < 7) cnt3++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{sel: imm_sel, imm: imm, base: base, has_exact: pend_has, exact: pend_exact});
        acc = 1'b1;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cnt16 = 0;
      cnt3  = 0;
      held  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b,
                      input bit hx, input logic [31:0] x);
    in_valid = 1'b1; imm_sel = s; imm = i; base = b;
    pend_has = hx; pend_exact = x;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", acc, 1);
    in_valid = 1'b0;
    pend_has = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic gen_item();
    logic [31:0]        r;
    logic signed [31:0] t;
    int                 w, mode;
    imm_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
    r    = $urandom;
    w    = (imm_sel == SEL_B) ? 13 : (imm_sel == SEL_J) ? 21 : 12;
    mode = $urandom_range(0, 3);
    case (mode)
      0: imm = r;
      1, 2: begin
        if (mode == 2) w = w + 1;
        t   = r << (32 - w);
        imm = t >>> (32 - w);
        if (mode == 1 && (imm_sel == SEL_B || imm_sel == SEL_J)) imm[0] = 1'b0;
      end
      default: imm = r & 32'hFFFF_F000;
    endcase
    base = $urandom;
  endtask

  logic [31:0] bp_imm[3];
  int          idx;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm_sel = 3'd0; imm = 32'd0; base = 32'd0;
    cnt16 = 0; cnt3 = 0; pend_has = 1'b0; pend_exact = 32'd0;
    acc = 1'b0; held = 1'b0; held_inst = 32'd0; held_err = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // latency: valid appears after the edge following the accept edge
    send(SEL_I, 32'hFFFF_FFFF, 32'h0000_0013, 1, 32'hFFF0_0013);
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    drain();

    send(SEL_B, 32'h0000_0FFE, 32'h0000_0063, 1, 32'h7E00_0FE3);
    send(SEL_B, 32'h0000_1001, 32'h0000_0063, 1, 32'h0000_0063);
    send(SEL_U, 32'h1234_5000, 32'h0000_0037, 1, 32'h1234_5037);
    send(SEL_U, 32'h1234_5001, 32'h0000_0037, 1, 32'h0000_0037);
    send(SEL_J, 32'hFFFF_FFFE, 32'h0000_006F, 1, 32'hFFFF_F06F);
    send(SEL_J, 32'h0010_0000, 32'h0000_006F, 1, 32'h0000_006F);
    send(3'd7,  32'h0000_0004, 32'h0000_0013, 1, 32'h0000_0013);
    send(SEL_S, 32'hFFFF_F800, 32'h0000_0023, 1, 32'h8000_0023);
    drain();
    #1 chk("dir_err_cnt", err_cnt, 4);

    // backpressure: two slots fill, third is refused until release
    bp_imm[0] = 32'd1; bp_imm[1] = 32'd2; bp_imm[2] = 32'd3;
    out_ready = 1'b0;
    idx = 0;
    repeat (3) begin
      in_valid = 1'b1; imm_sel = SEL_I; imm = bp_imm[idx]; base = 32'h13;
      pend_has = 1'b1; pend_exact = {bp_imm[idx][11:0], 20'h00013};
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    #1 chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && idx < 3; k++) begin
      imm = bp_imm[idx]; pend_exact = {bp_imm[idx][11:0], 20'h00013};
      tick();
      if (acc) idx++;
    end
    chk("bp_third", idx, 3);
    pend_has = 1'b0;
    drain();

    // reset with both stages occupied
    out_ready = 1'b0;
    send(SEL_U, 32'h0000_0001, 32'h37, 0, 32'h0);
    send(SEL_I, 32'h0000_0005, 32'h13, 0, 32'h0);
    #1 chk("mid_full", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_err_cnt", err_cnt, 0);
    chk("mid_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // saturation of the narrow counter
    for (int k = 0; k < 10; k++) send(SEL_U, 32'h0000_0001, 32'h37, 0, 32'h0);
    drain();
    #1;
    chk("sat_hold", s_err_cnt, 7);
    chk("sat_wide", err_cnt, 10);

    // random valid/ready soak
    in_valid = 1'b0;
    acc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        gen_item();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
